// File: rtl/ncl_arb_pkg.sv
// Shared types and constants for the clocked front end of the NCL up/down ring.
package ncl_arb_pkg;

    localparam int RAILS = 6;
    localparam logic [RAILS-1:0] SHADOW_RST = 6'b000001;

    typedef enum logic [2:0] {
        IDLE,
        UP_DATA,
        UP_NULL,
        DN_DATA,
        DN_NULL
    } arb_state_t;

endpackage

// File: rtl/ncl_comp_sync.sv
// Multi-flop synchroniser for an asynchronous NCL completion signal.
module ncl_comp_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic init,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] chain;

    always_ff @(posedge clk or posedge init) begin
        if (init) begin
            chain <= '0;
        end else begin
            chain[0] <= d;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
                chain[i] <= chain[i-1];
            end
        end
    end

    assign q = chain[SYNC_STAGES-1];

endmodule

// File: rtl/updn_count_issuer.sv
// Nets up/down request pulses into a signed pending count and issues each unit
// as a four-phase NCL token on countup/countdn, mirroring the ring value one-hot.
module updn_count_issuer
    import ncl_arb_pkg::*;
#(
    parameter int PEND_W      = 4,
    parameter int SYNC_STAGES = 2,
    parameter int RAILS       = ncl_arb_pkg::RAILS
) (
    input  logic                     clk,
    input  logic                     init,
    input  logic                     up_req,
    input  logic                     dn_req,
    output logic                     up_ready,
    output logic                     dn_ready,
    output logic                     countup,
    input  logic                     countupCOMP,
    output logic                     countdn,
    input  logic                     countdnCOMP,
    output logic signed [PEND_W-1:0] pending,
    output logic [RAILS-1:0]         shadow_rail,
    output logic                     shadow_zero,
    output logic                     ovf
);

    localparam int IMAX = 2 ** (PEND_W - 1) - 1;
    localparam int IMIN = -(2 ** (PEND_W - 1));
    localparam logic signed [PEND_W-1:0] PMAX = PEND_W'(IMAX);
    localparam logic signed [PEND_W-1:0] PMIN = PEND_W'(IMIN);

    arb_state_t state;
    logic       upc_s, dnc_s;
    logic       acc_up, acc_dn, consume_up, consume_dn, drop;
    logic       pend_pos, pend_neg;
    int         sum;
    logic signed [PEND_W-1:0] pending_nx;

    ncl_comp_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_up (
        .clk  (clk),
        .init (init),
        .d    (countupCOMP),
        .q    (upc_s)
    );

    ncl_comp_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_dn (
        .clk  (clk),
        .init (init),
        .d    (countdnCOMP),
        .q    (dnc_s)
    );

    assign up_ready    = (pending != PMAX);
    assign dn_ready    = (pending != PMIN);
    assign acc_up      = up_req & up_ready;
    assign acc_dn      = dn_req & dn_ready;
    assign drop        = (up_req & ~up_ready) | (dn_req & ~dn_ready);
    assign consume_up  = (state == UP_DATA) & upc_s;
    assign consume_dn  = (state == DN_DATA) & dnc_s;
    assign pend_neg    = pending[PEND_W-1];
    assign pend_pos    = ~pending[PEND_W-1] & (|pending);
    assign shadow_zero = shadow_rail[0];

    // A consumption in the opposite direction of newly accepted requests can
    // step one past the range; clamp rather than wrap the sign.
    always_comb begin
        sum = int'(pending) + int'(acc_up) - int'(acc_dn)
            - int'(consume_up) + int'(consume_dn);
        if (sum > IMAX)
            pending_nx = PMAX;
        else if (sum < IMIN)
            pending_nx = PMIN;
        else
            pending_nx = PEND_W'(sum);
    end

    always_ff @(posedge clk or posedge init) begin
        if (init) begin
            state       <= IDLE;
            countup     <= 1'b0;
            countdn     <= 1'b0;
            pending     <= '0;
            ovf         <= 1'b0;
            shadow_rail <= SHADOW_RST;
        end else begin
            pending <= pending_nx;
            if (drop)
                ovf <= 1'b1;
            case (state)
                IDLE: begin
                    if (pend_pos) begin
                        countup <= 1'b1;
                        state   <= UP_DATA;
                    end else if (pend_neg) begin
                        countdn <= 1'b1;
                        state   <= DN_DATA;
                    end
                end
                UP_DATA: begin
                    if (upc_s) begin
                        countup     <= 1'b0;
                        shadow_rail <= {shadow_rail[RAILS-2:0], shadow_rail[RAILS-1]};
                        state       <= UP_NULL;
                    end
                end
                UP_NULL: begin
                    if (!upc_s)
                        state <= IDLE;
                end
                DN_DATA: begin
                    if (dnc_s) begin
                        countdn     <= 1'b0;
                        shadow_rail <= {shadow_rail[0], shadow_rail[RAILS-1:1]};
                        state       <= DN_NULL;
                    end
                end
                DN_NULL: begin
                    if (!dnc_s)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_updn_count_issuer.sv
// Directed bench for updn_count_issuer with a delayed-ack ring model and a token scoreboard.
module tb_updn_count_issuer;

    logic       clk = 1'b0;
    logic       init;
    logic       up_req, dn_req;
    logic       up_ready, dn_ready;
    logic       countup, countupCOMP;
    logic       countdn, countdnCOMP;
    logic [3:0] pending;
    logic [5:0] shadow_rail;
    logic       shadow_zero;
    logic       ovf;

    typedef struct {
        logic       dn;
        logic [5:0] sh;
    } tok_t;

    tok_t       sbq[$];
    logic [5:0] exp_shadow;
    int         tests = 0;
    int         fails = 0;
    int         tokens = 0;
    logic       stall = 1'b0;

    updn_count_issuer #(.PEND_W(4), .SYNC_STAGES(2), .RAILS(6)) dut (
        .clk         (clk),
        .init        (init),
        .up_req      (up_req),
        .dn_req      (dn_req),
        .up_ready    (up_ready),
        .dn_ready    (dn_ready),
        .countup     (countup),
        .countupCOMP (countupCOMP),
        .countdn     (countdn),
        .countdnCOMP (countdnCOMP),
        .pending     (pending),
        .shadow_rail (shadow_rail),
        .shadow_zero (shadow_zero),
        .ovf         (ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic u, input logic d);
        up_req = u;
        dn_req = d;
        tick();
        up_req = 1'b0;
        dn_req = 1'b0;
    endtask

    task automatic push_tok(input logic d);
        tok_t t;
        if (d)
            exp_shadow = {exp_shadow[0], exp_shadow[5:1]};
        else
            exp_shadow = {exp_shadow[4:0], exp_shadow[5]};
        t.dn = d;
        t.sh = exp_shadow;
        sbq.push_back(t);
    endtask

    task automatic do_reset();
        #2;
        init = 1'b1;
        #1;
        check("rst_countup", 32'(countup), 32'd0);
        check("rst_countdn", 32'(countdn), 32'd0);
        check("rst_pending", 32'(pending), 32'd0);
        check("rst_shadow", 32'(shadow_rail), 32'h01);
        check("rst_shadow_zero", 32'(shadow_zero), 32'd1);
        check("rst_ovf", 32'(ovf), 32'd0);
        sbq.delete();
        exp_shadow = 6'b000001;
        tick();
        tick();
        init = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        logic done;
        done = 1'b0;
        for (int i = 0; i < budget && !done; i++) begin
            tick();
            done = (pending == 4'd0) && !countup && !countdn && !countupCOMP
                && !countdnCOMP && (sbq.size() == 0);
        end
        check("idle_timeout", 32'(done), 32'd1);
        repeat (6) tick();
    endtask

    task automatic token_seen(input logic d);
        tok_t e;
        tokens++;
        if (sbq.size() == 0) begin
            check("unexpected_token", 32'd1, 32'd0);
        end else begin
            e = sbq.pop_front();
            check("token_dir", 32'(d), 32'(e.dn));
            check("token_shadow", 32'(shadow_rail), 32'(e.sh));
        end
    endtask

    // Ring model: completion follows its rail after three cycles unless stalled.
    initial begin
        int uc, dc;
        uc = 0;
        dc = 0;
        countupCOMP = 1'b0;
        countdnCOMP = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (init) begin
                countupCOMP = 1'b0;
                countdnCOMP = 1'b0;
                uc = 0;
                dc = 0;
            end else begin
                if (countup != countupCOMP && !stall) begin
                    uc++;
                    if (uc >= 3) begin
                        countupCOMP = countup;
                        uc = 0;
                    end
                end else uc = 0;
                if (countdn != countdnCOMP && !stall) begin
                    dc++;
                    if (dc >= 3) begin
                        countdnCOMP = countdn;
                        dc = 0;
                    end
                end else dc = 0;
            end
        end
    end

    // Monitor: every DATA->NULL transition of a rail is one consumed token.
    initial begin
        logic pu, pd;
        pu = 1'b0;
        pd = 1'b0;
        forever begin
            @(negedge clk);
            check("rails_exclusive", 32'(countup & countdn), 32'd0);
            if (init) begin
                pu = 1'b0;
                pd = 1'b0;
            end else begin
                if (pu && !countup) token_seen(1'b0);
                if (pd && !countdn) token_seen(1'b1);
                pu = countup;
                pd = countdn;
            end
        end
    end

    initial begin
        int t0;
        init       = 1'b1;
        up_req     = 1'b0;
        dn_req     = 1'b0;
        exp_shadow = 6'b000001;
        tick();
        do_reset();
        tick();

        // Three up pulses, acked by the ring model.
        t0 = tokens;
        for (int i = 0; i < 3; i++) begin
            push_tok(1'b0);
            pulse(1'b1, 1'b0);
        end
        check("three_up_pending", 32'(pending), 32'd3);
        wait_idle(300);
        check("three_up_tokens", 32'(tokens - t0), 32'd3);
        check("three_up_shadow", 32'(shadow_rail), 32'h08);
        check("three_up_pending_end", 32'(pending), 32'd0);

        // Simultaneous up and down cancel.
        t0 = tokens;
        pulse(1'b1, 1'b1);
        check("cancel_pending", 32'(pending), 32'd0);
        repeat (20) tick();
        check("cancel_no_token", 32'(tokens - t0), 32'd0);
        check("cancel_countup", 32'(countup), 32'd0);
        check("cancel_countdn", 32'(countdn), 32'd0);

        // Down from reset wraps the shadow to rail 5.
        do_reset();
        tick();
        t0 = tokens;
        push_tok(1'b1);
        pulse(1'b0, 1'b1);
        check("wrap_pending", 32'(pending), 32'hF);
        wait_idle(300);
        check("wrap_tokens", 32'(tokens - t0), 32'd1);
        check("wrap_shadow", 32'(shadow_rail), 32'h20);
        check("wrap_shadow_zero", 32'(shadow_zero), 32'd0);

        // Saturation with the ring stalled.
        do_reset();
        stall = 1'b1;
        tick();
        for (int i = 0; i < 7; i++) pulse(1'b1, 1'b0);
        check("sat_pending", 32'(pending), 32'd7);
        check("sat_up_ready", 32'(up_ready), 32'd0);
        check("sat_ovf_clear", 32'(ovf), 32'd0);
        check("sat_countup_held", 32'(countup), 32'd1);
        pulse(1'b1, 1'b0);
        check("sat_drop_pending", 32'(pending), 32'd7);
        check("sat_ovf_set", 32'(ovf), 32'd1);
        pulse(1'b0, 1'b1);
        check("sat_dn_pending", 32'(pending), 32'd6);
        check("sat_ovf_sticky", 32'(ovf), 32'd1);

        // Reset while the up token is still in DATA.
        check("midtok_countup_before", 32'(countup), 32'd1);
        do_reset();
        stall = 1'b0;
        t0 = tokens;
        repeat (15) tick();
        check("midtok_idle_countup", 32'(countup), 32'd0);
        check("midtok_idle_countdn", 32'(countdn), 32'd0);
        check("midtok_no_token", 32'(tokens - t0), 32'd0);
        check("midtok_pending", 32'(pending), 32'd0);
        check("midtok_shadow", 32'(shadow_rail), 32'h01);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
